adder_sum_accumulator: RTL
==========================

Name: adder_sum_accumulator

Overview:
- Downstream consumer of the registered adder's sum bus.
- Accumulates a stream of SUM_WIDTH-bit sums into frames of FRAME_LEN beats and emits one accumulated total per frame over a valid/ready interface.
- Sits between the adder and any result sink, such as a checker, an output serializer or an I/O register bank.
- Applies backpressure upstream only when a completed frame cannot be handed off.

Parameters:
- SUM_WIDTH, 40, width of the incoming sum (adder width + 1).
- ACC_WIDTH, 48, width of the accumulator and the output total; must be >= SUM_WIDTH.
- FRAME_LEN, 16, beats per frame; must be >= 2.

Ports:
- clk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sum_in  in  SUM_WIDTH  sum from the adder stage.
- sum_valid  in  1  sum_in is valid this cycle.
- flush  in  1  close the current frame early; qualified like a beat.
- in_ready  out  1  the block accepts sum_valid/flush this cycle.
- out_total  out  ACC_WIDTH  accumulated frame total.
- out_count  out  $clog2(FRAME_LEN+1)  number of beats in the emitted frame.
- out_ovf  out  1  the frame's accumulation exceeded ACC_WIDTH.
- out_valid  out  1  the output record is valid.
- out_ready  in  1  the sink accepts the output record.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state: acc=0, cnt=0, ovf_acc=0, out_valid=0, out_total=0, out_count=0, out_ovf=0.
  - rst mid-frame discards the partial frame and any held output record; nothing is emitted.
- Beat acceptance: a beat is accepted when sum_valid && in_ready.
  - The accumulator adds zero-extended sum_in.
  - ovf_acc sets on carry-out of the ACC_WIDTH addition.
  - cnt increments.
- Flush acceptance: a flush is accepted when flush && in_ready.
- Frame close: the frame closes when either of these holds:
  - an accepted beat makes cnt+1 == FRAME_LEN;
  - an accepted flush occurs with cnt>0 or with a beat in the same cycle.
- Close actions, all on the same edge:
  - The output register loads the closing total (including any same-cycle beat), the beat count and the overflow flag.
  - out_valid goes to 1.
  - acc, cnt and ovf_acc clear to 0.
  - Latency: out_valid is asserted the cycle after the closing beat is accepted.
- Empty flush: a flush with cnt==0 and no beat is consumed with no output.
- Output handshake: the record transfers when out_valid && out_ready; out_valid then drops unless a new close occurs on the same edge.
- Output register state machine:
  - OUT_EMPTY -> OUT_FULL on close.
  - OUT_FULL -> OUT_EMPTY on transfer without a close.
  - OUT_FULL stays OUT_FULL on transfer with a simultaneous close (back-to-back, no bubble).
  - While OUT_FULL, out_total/out_count/out_ovf hold stable.
- Backpressure:
  - in_ready = !(out_valid && !out_ready && close_would_occur).
  - close_would_occur means cnt==FRAME_LEN-1, or flush is asserted.
  - Non-closing beats are always accepted, so accumulation of the next frame continues while the output is held.
- Width rules:
  - Accumulation is modulo 2^ACC_WIDTH unless the optional feature is enabled.
  - out_count equals FRAME_LEN for full frames and is in 1..FRAME_LEN-1 for flushed frames.
- Upstream contract: the adder stage is free-running, so its driver holds sum_in/sum_valid while in_ready=0.

Optional Feature:
- Macro: ACCUM_SATURATE_EN.
- Defined: on carry-out, acc clamps to all-ones and stays there for the rest of the frame; out_ovf=1.
- Undefined: acc wraps modulo 2^ACC_WIDTH; out_ovf=1 marks that the wrap occurred.
- In both cases, out_ovf clears for the next frame.

Decomposition:
- Shared package adder_stream_pkg contains:
  - SUM_WIDTH default;
  - ACC_WIDTH default;
  - count-width localparam function;
  - output record typedef {total, count, ovf}.
- One sub-module, accum_out_reg: the single-entry valid/ready holding register with the same-edge transfer+load rule.

Test Plan:
- FRAME_LEN=4; beats 1,2,3,4 with out_ready=1 -> one cycle after beat 4: out_valid=1, out_total=10, out_count=4, out_ovf=0; acc restarts at 0.
- Beats 5,6, then flush alone -> out_total=11, out_count=2. A flush with cnt==0 -> no out_valid.
- out_ready=0; 8 beats of value 1 -> first record (4,4) is held; beats 5-7 are accepted; beat 8 sees in_ready=0 until out_ready=1; then the records arrive in order (4,4),(4,4) with no loss.
- Continuous beats and out_ready=1 -> out_valid is a 1-cycle pulse every 4 cycles; in_ready stays 1 throughout.
- ACC_WIDTH=41; three beats of 2^40-1 and a flush:
  - without ACCUM_SATURATE_EN: out_total=(3*(2^40-1)) mod 2^41, out_ovf=1;
  - with ACCUM_SATURATE_EN: out_total=2^41-1, out_ovf=1.
- rst asserted with cnt=3 and out_valid=1 -> next cycle out_valid=0, in_ready=1; the following frame of 1,1,1,1 gives out_total=4.

Source files
------------

// File: rtl/adder_sum_accumulator_pkg.sv
// Shared types and defaults for the adder sum stream and its frame accumulator.
package adder_stream_pkg;

  localparam int SUM_WIDTH_DEF = 40;
  localparam int ACC_WIDTH_DEF = 48;
  localparam int FRAME_LEN_DEF = 16;

  function automatic int cnt_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

  localparam int CNT_WIDTH_DEF = cnt_w(FRAME_LEN_DEF);

  typedef struct packed {
    logic [ACC_WIDTH_DEF-1:0] total;
    logic [CNT_WIDTH_DEF-1:0] count;
    logic                     ovf;
  } out_rec_t;

endpackage

// File: rtl/adder_sum_accumulator_if.sv
// Sum-stream input and frame-total output handshakes of the accumulator.
interface adder_sum_accumulator_if
  import adder_stream_pkg::*;
#(
  parameter int SUM_WIDTH = SUM_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
);
  localparam int CNT_WIDTH = cnt_w(FRAME_LEN);

  logic [SUM_WIDTH-1:0] sum_in;
  logic                 sum_valid;
  logic                 flush;
  logic                 in_ready;
  logic [ACC_WIDTH-1:0] out_total;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_ovf;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output sum_in, sum_valid, flush, out_ready,
    input  in_ready, out_total, out_count, out_ovf, out_valid
  );

  modport slave (
    input  sum_in, sum_valid, flush, out_ready,
    output in_ready, out_total, out_count, out_ovf, out_valid
  );
endinterface

// File: rtl/adder_sum_accumulator_accum_out_reg.sv
// Single-entry valid/ready holding register; a load on the same edge as a
// transfer keeps the entry full so back-to-back records see no bubble.
module accum_out_reg
  import adder_stream_pkg::*;
#(
  parameter type rec_t = out_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  rec_t i_rec,
  input  logic i_ready,
  output logic o_valid,
  output rec_t o_rec
);
  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_FULL  = 1'b1;

  logic [0:0] r_state;
  rec_t       r_rec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OUT_EMPTY;
      r_rec   <= '0;
    end else if (i_load) begin
      r_state <= OUT_FULL;
      r_rec   <= i_rec;
    end else if (r_state == OUT_FULL && i_ready) begin
      r_state <= OUT_EMPTY;
    end
  end

  assign o_valid = (r_state == OUT_FULL);
  assign o_rec   = r_rec;
endmodule

// File: rtl/adder_sum_accumulator.sv
// Frame accumulator for the adder sum stream. Define ACCUM_SATURATE_EN to
// clamp the total at all-ones on overflow instead of wrapping.
module adder_sum_accumulator
  import adder_stream_pkg::*;
#(
  parameter int SUM_WIDTH = SUM_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_sum_accumulator_if.slave  bus
);
  localparam int CW = cnt_w(FRAME_LEN);

  typedef struct packed {
    logic [ACC_WIDTH-1:0] total;
    logic [CW-1:0]        count;
    logic                 ovf;
  } rec_t;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_ovf;

  logic [ACC_WIDTH:0]   w_acc_sum;
  logic [ACC_WIDTH-1:0] w_acc_step;
  logic [ACC_WIDTH-1:0] w_acc_new;
  logic [CW-1:0]        w_cnt_new;
  logic                 w_ovf_new;
  logic                 w_last;
  logic                 w_close_would;
  logic                 w_beat;
  logic                 w_flush;
  logic                 w_close;
  logic                 w_out_valid;
  rec_t                 w_rec;
  rec_t                 w_out_rec;

  assign w_acc_sum = {1'b0, r_acc} + (ACC_WIDTH+1)'(bus.sum_in);

`ifdef ACCUM_SATURATE_EN
  assign w_acc_step = w_acc_sum[ACC_WIDTH] ? '1 : w_acc_sum[ACC_WIDTH-1:0];
`else
  assign w_acc_step = w_acc_sum[ACC_WIDTH-1:0];
`endif

  // Only a frame-closing request is stalled; partial beats always flow.
  assign w_last        = (r_cnt == CW'(FRAME_LEN - 1));
  assign w_close_would = w_last || bus.flush;
  assign bus.in_ready  = !(w_out_valid && !bus.out_ready && w_close_would);

  assign w_beat  = bus.sum_valid && bus.in_ready;
  assign w_flush = bus.flush && bus.in_ready;
  assign w_close = (w_beat && w_last) || (w_flush && (r_cnt != '0 || w_beat));

  assign w_acc_new = w_beat ? w_acc_step : r_acc;
  assign w_cnt_new = r_cnt + CW'(w_beat);
  assign w_ovf_new = r_ovf | (w_beat & w_acc_sum[ACC_WIDTH]);

  assign w_rec = '{total: w_acc_new, count: w_cnt_new, ovf: w_ovf_new};

  always_ff @(posedge clk) begin
    if (rst || w_close) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_acc_new;
      r_cnt <= w_cnt_new;
      r_ovf <= w_ovf_new;
    end
  end

  accum_out_reg #(.rec_t(rec_t)) u_out (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_close),
    .i_rec   (w_rec),
    .i_ready (bus.out_ready),
    .o_valid (w_out_valid),
    .o_rec   (w_out_rec)
  );

  assign bus.out_valid = w_out_valid;
  assign bus.out_total = w_out_rec.total;
  assign bus.out_count = w_out_rec.count;
  assign bus.out_ovf   = w_out_rec.ovf;
endmodule
